pdm_dual_xmit: RTL and testbench

PDM_DUAL_XMIT -- requirements
Module: pdm_dual_xmit

---
 rtl/pdm_pkg.sv | 17 +
 rtl/pdm_sd_mod.sv | 36 +++
 rtl/pdm_dual_xmit.sv | 131 +++++++++++++
 tb/tb_pdm_dual_xmit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and types for the dual-channel PDM transmitter.
package pdm_pkg;

  localparam int DIV_W = 8;
  localparam int PCM_W = 16;
  localparam int ACC_W = 18;

  // Feedback levels subtracted from the integrator for a 1 / 0 output bit
  localparam logic signed [ACC_W-1:0] FB_POS = 18'sd32767;
  localparam logic signed [ACC_W-1:0] FB_NEG = -18'sd32768;

  typedef struct packed {
    logic [PCM_W-1:0] l;
    logic [PCM_W-1:0] r;
  } pcm_pair_t;

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order sigma-delta modulator; advances one step per i_step strobe.
module pdm_sd_mod
  import pdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic [PCM_W-1:0] i_x,
  output logic             o_bit
);

  logic signed [ACC_W-1:0] r_acc;
  logic                    r_bit;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_fb;
  logic                    w_bit;

  assign w_x   = {{(ACC_W-PCM_W){i_x[PCM_W-1]}}, i_x};
  assign w_sum = r_acc + w_x;
  assign w_bit = ~w_sum[ACC_W-1];
  assign w_fb  = w_bit ? FB_POS : FB_NEG;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_bit <= 1'b0;
    end else if (i_step) begin
      r_acc <= w_sum - w_fb;
      r_bit <= w_bit;
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/pdm_dual_xmit.sv
// Stereo PCM to interleaved PDM transmitter: left bit on pdm_clk high, right bit on low,
// one new sample pair every OSR pdm_clk periods via a single-entry holding register.
module pdm_dual_xmit
  import pdm_pkg::*;
#(
  parameter int OSR = 64,
  parameter int SW  = PCM_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_left,
  input  logic [SW-1:0] in_right,
  output logic          pdm_clk,
  output logic          pdm_data,
  output logic          underrun
);

  localparam int SLOT_W = $clog2(OSR);

  logic [DIV_W-1:0]  r_clk_div;
  logic              r_mode_q;
  logic              r_pclk_d;
  logic [SLOT_W-1:0] r_slot;
  logic              r_full;
  pcm_pair_t         r_hold;
  pcm_pair_t         r_cur;
  logic              r_data;
  logic              r_underrun;

  logic              w_pclk;
  logic              w_rise;
  logic              w_fall;
  logic              w_wrap;
  logic              w_accept;
  logic              w_load;
  logic              w_lbit;
  logic              w_rbit;
  logic [PCM_W-1:0]  w_in_l;
  logic [PCM_W-1:0]  w_in_r;

  // Left-align incoming samples to the 16-bit modulator input
  if (SW >= PCM_W) begin : g_trunc
    assign w_in_l = in_left[SW-1 -: PCM_W];
    assign w_in_r = in_right[SW-1 -: PCM_W];
  end else begin : g_pad
    assign w_in_l = {in_left,  {(PCM_W-SW){1'b0}}};
    assign w_in_r = {in_right, {(PCM_W-SW){1'b0}}};
  end

  assign w_pclk   = r_mode_q ? r_clk_div[DIV_W-1] : r_clk_div[DIV_W-2];
  assign w_rise   =  w_pclk & ~r_pclk_d;
  assign w_fall   = ~w_pclk &  r_pclk_d;
  assign w_wrap   = w_rise & (r_slot == SLOT_W'(OSR-1));
  assign w_accept = in_valid & ~r_full;
  assign w_load   = w_wrap & r_full;

  // Rate select is only sampled under reset so the bit clock never glitches mid-stream
  always_ff @(posedge clk) begin
    if (rst) r_mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_div <= '0;
      r_pclk_d  <= 1'b0;
    end else begin
      r_clk_div <= r_clk_div + 1'b1;
      r_pclk_d  <= w_pclk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_slot <= '0;
    else if (w_rise) r_slot <= w_wrap ? '0 : r_slot + 1'b1;
  end

  // Accept needs an empty holding register, so accept and load are mutually exclusive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_hold <= '0;
    end else begin
      if (w_load)        r_full <= 1'b0;
      else if (w_accept) r_full <= 1'b1;
      if (w_accept) begin
        r_hold.l <= w_in_l;
        r_hold.r <= w_in_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_cur <= '0;
    else if (w_load) r_cur <= r_hold;
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_underrun <= 1'b0;
    else if (w_wrap && !r_full) r_underrun <= 1'b1;
  end

  pdm_sd_mod u_mod_l (
    .clk    (clk),
    .rst    (rst),
    .i_step (w_fall),
    .i_x    (r_cur.l),
    .o_bit  (w_lbit)
  );

  pdm_sd_mod u_mod_r (
    .clk    (clk),
    .rst    (rst),
    .i_step (w_rise),
    .i_x    (r_cur.r),
    .o_bit  (w_rbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_data <= 1'b0;
    else     r_data <= w_pclk ? w_lbit : w_rbit;
  end

  assign pdm_clk  = w_pclk;
  assign pdm_data = r_data;
  assign in_ready = ~r_full;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_pdm_dual_xmit.sv
// Self-checking bench for pdm_dual_xmit: randomized pairs scored against a per-period channel model.
module tb_pdm_dual_xmit;

  localparam int OSR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        pdm_clk;
  logic        pdm_data;
  logic        underrun;

  int pass_cnt = 0;
  int total    = 0;
  int half     = 64;

  // Reference model state: one entry per channel plus the holding slot
  int          m_lacc, m_racc, m_rise;
  logic        m_lbit, m_rbit, m_full, m_und;
  logic [15:0] m_cur_l, m_cur_r, m_hold_l, m_hold_r;

  always #5 clk = ~clk;

  pdm_dual_xmit #(.OSR(OSR), .SW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_left  (in_left),
    .in_right (in_right),
    .pdm_clk  (pdm_clk),
    .pdm_data (pdm_data),
    .underrun (underrun)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog sim time exceeded, summary %0d/%0d", pass_cnt, total);
    $fatal(1, "watchdog");
  end

  task automatic mstep(inout int acc, output logic b, input logic [15:0] x);
    int sum;
    sum = acc + int'($signed(x));
    b   = (sum >= 0);
    acc = sum - (b ? 32767 : -32768);
  endtask

  task automatic model_reset();
    m_lacc = 0; m_racc = 0; m_rise = 0;
    m_lbit = 0; m_rbit = 0; m_full = 0; m_und = 0;
    m_cur_l = 0; m_cur_r = 0; m_hold_l = 0; m_hold_r = 0;
  endtask

  // One pdm_clk period: rise (right step, slot wrap, offer), high phase, fall (left step), low phase
  task automatic model_period(input bit offer, input logic [15:0] l, input logic [15:0] r,
                              output logic el, output logic er, output logic erp,
                              output logic erq, output logic eu);
    erp = !m_full;
    m_rise++;
    mstep(m_racc, m_rbit, m_cur_r);
    if (m_rise % OSR == 0) begin
      if (m_full) begin
        m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_full = 0;
      end else begin
        m_und = 1;
      end
    end
    if (offer && erp) begin
      m_hold_l = l; m_hold_r = r; m_full = 1;
    end
    el = m_lbit;
    mstep(m_lacc, m_lbit, m_cur_l);
    er  = m_rbit;
    erq = !m_full;
    eu  = m_und;
  endtask

  task automatic run_period(input bit offer, input logic [15:0] l, input logic [15:0] r,
                            output logic ol, output logic orr, output logic orp,
                            output logic orq, output logic ou, output int nw);
    int n2;
    nw = 0;
    while (pdm_clk !== 1'b1 && nw < 600) begin @(negedge clk); nw++; end
    if (pdm_clk !== 1'b1) begin
      total++;
      $display("FAIL rise_timeout waited %0d clk, required a pdm_clk rise", nw);
    end
    orp = in_ready;
    in_valid = offer; in_left = l; in_right = r;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (half/2 - 1) @(negedge clk);
    ol = pdm_data;
    n2 = 0;
    while (pdm_clk !== 1'b0 && n2 < 600) begin @(negedge clk); n2++; end
    if (pdm_clk !== 1'b0) begin
      total++;
      $display("FAIL fall_timeout waited %0d clk, required a pdm_clk fall", n2);
    end
    repeat (half/2) @(negedge clk);
    orr = pdm_data; orq = in_ready; ou = underrun;
  endtask

  task automatic measure(output int hi, output int lo);
    int n;
    n = 0; hi = 0; lo = 0;
    while (pdm_clk !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    while (pdm_clk === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
    while (pdm_clk === 1'b0 && lo < 1000) begin lo++; @(negedge clk); end
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1; mode = m; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    half = m ? 128 : 64;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (pdm_clk !== 1'b0)  $display("FAIL reset_pdm_clk got %b want 0", pdm_clk);   else pass_cnt++;
    total++; if (pdm_data !== 1'b0) $display("FAIL reset_pdm_data got %b want 0", pdm_data); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else pass_cnt++;
  endtask

  task automatic test_rate();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    int nw, hi, lo;
    do_reset(1'b0);
    run_period(1'b0, 16'h0, 16'h0, ol, orr, orp, orq, ou, nw);
    model_period(1'b0, 16'h0, 16'h0, el, er, erp, erq, eu);
    total++; if (nw !== 64) $display("FAIL rate0_first_rise got %0d want 64", nw); else pass_cnt++;
    measure(hi, lo);
    total++; if (hi !== 64)       $display("FAIL rate0_high got %0d want 64", hi);          else pass_cnt++;
    total++; if (hi + lo !== 128) $display("FAIL rate0_period got %0d want 128", hi + lo); else pass_cnt++;

    do_reset(1'b1);
    for (int p = 1; p <= 3; p++) begin
      run_period(1'b0, 16'h0, 16'h0, ol, orr, orp, orq, ou, nw);
      model_period(1'b0, 16'h0, 16'h0, el, er, erp, erq, eu);
      if (p == 1) begin
        total++; if (nw !== 128) $display("FAIL rate1_first_rise got %0d want 128", nw); else pass_cnt++;
      end
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL rate1_bits p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
    end
    measure(hi, lo);
    total++; if (hi !== 128)      $display("FAIL rate1_high got %0d want 128", hi);         else pass_cnt++;
    total++; if (hi + lo !== 256) $display("FAIL rate1_period got %0d want 256", hi + lo); else pass_cnt++;
    mode = 1'b0;
    measure(hi, lo);
    total++; if (hi + lo !== 256) $display("FAIL rate_mode_ignored got %0d want 256", hi + lo); else pass_cnt++;
  endtask

  task automatic test_pattern();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    int nw;
    bit off;
    do_reset(1'b0);
    for (int p = 1; p <= OSR + 8; p++) begin
      off = (p == 1);
      run_period(off, 16'h7FFF, 16'h8000, ol, orr, orp, orq, ou, nw);
      model_period(off, 16'h7FFF, 16'h8000, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL pattern_model p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
      if (p <= OSR) begin
        total++;
        if (orr !== 1'(p % 2)) $display("FAIL pattern_zero_right p%0d got %b want %b", p, orr, 1'(p % 2));
        else pass_cnt++;
      end
      if (p >= 2 && p <= OSR) begin
        total++;
        if (ol !== 1'((p - 1) % 2)) $display("FAIL pattern_zero_left p%0d got %b want %b", p, ol, 1'((p - 1) % 2));
        else pass_cnt++;
      end
      if (p > OSR) begin
        total++;
        if ({ol, orr} !== 2'b10) $display("FAIL pattern_full_scale p%0d l,r got %b want 10", p, {ol, orr});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_handshake();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    logic [15:0] al, ar, bl, br, dl, dr;
    int nw;
    bit off;
    al = 16'($urandom); ar = 16'($urandom); bl = 16'($urandom); br = 16'($urandom);
    do_reset(1'b0);
    for (int p = 1; p <= 2 * OSR + 3; p++) begin
      off = (p <= OSR + 1);
      dl = (p == 1) ? al : bl;
      dr = (p == 1) ? ar : br;
      run_period(off, dl, dr, ol, orr, orp, orq, ou, nw);
      model_period(off, dl, dr, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL handshake_model p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
      if (p == 2 || p == OSR) begin
        total++; if (orp !== 1'b0) $display("FAIL handshake_held_off p%0d in_ready got %b want 0", p, orp); else pass_cnt++;
      end
      if (p == OSR) begin
        total++; if (orq !== 1'b1) $display("FAIL handshake_load p%0d in_ready got %b want 1", p, orq); else pass_cnt++;
      end
      if (p == OSR + 1) begin
        total++; if ({orp, orq} !== 2'b10) $display("FAIL handshake_accept_b got %b want 10", {orp, orq}); else pass_cnt++;
      end
    end
    total++; if (underrun !== 1'b0) $display("FAIL handshake_no_underrun got %b want 0", underrun); else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    logic [15:0] ul, ur;
    int nw;
    bit off;
    ul = 16'($urandom); ur = 16'($urandom);
    do_reset(1'b0);
    for (int p = 1; p <= 2 * OSR + 6; p++) begin
      off = (p == 1);
      run_period(off, ul, ur, ol, orr, orp, orq, ou, nw);
      model_period(off, ul, ur, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL underrun_model p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
      if (p == 2 * OSR - 1) begin
        total++; if (ou !== 1'b0) $display("FAIL underrun_early got %b want 0", ou); else pass_cnt++;
      end
      if (p == 2 * OSR) begin
        total++; if (ou !== 1'b1) $display("FAIL underrun_second_wrap got %b want 1", ou); else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap_accept();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    logic [15:0] cl, cr;
    int nw;
    bit off;
    cl = 16'($urandom); cr = 16'($urandom);
    do_reset(1'b0);
    for (int p = 1; p <= 2 * OSR + 4; p++) begin
      off = (p == OSR);
      run_period(off, cl, cr, ol, orr, orp, orq, ou, nw);
      model_period(off, cl, cr, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL wrap_accept_model p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
      if (p == OSR) begin
        total++; if ({ou, orq} !== 2'b10) $display("FAIL wrap_accept_same_clk und,rdy got %b want 10", {ou, orq}); else pass_cnt++;
      end
      if (p == 2 * OSR) begin
        total++; if (orq !== 1'b1) $display("FAIL wrap_accept_load got %b want 1", orq); else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    logic [15:0] rl, rr;
    int nw;
    bit off;
    do_reset(1'b0);
    for (int p = 1; p <= 4 * OSR; p++) begin
      off = ($urandom_range(0, 2) == 0);
      rl = 16'($urandom); rr = 16'($urandom);
      run_period(off, rl, rr, ol, orr, orp, orq, ou, nw);
      model_period(off, rl, rr, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL random_model p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
    end
  endtask

  task automatic test_midreset();
    logic ol, orr, orp, orq, ou, el, er, erp, erq, eu;
    int nw;
    bit off;
    do_reset(1'b0);
    for (int p = 1; p <= 2 * OSR + 2; p++) begin
      off = (p == 1) || (p == 2 * OSR + 2);
      run_period(off, 16'h0, 16'h0, ol, orr, orp, orq, ou, nw);
      model_period(off, 16'h0, 16'h0, el, er, erp, erq, eu);
      total++;
      if ({ol, orr, orp, orq, ou} !== {el, er, erp, erq, eu})
        $display("FAIL midreset_stream p%0d l,r,rdy0,rdy1,und got %b want %b", p,
                 {ol, orr, orp, orq, ou}, {el, er, erp, erq, eu});
      else pass_cnt++;
    end
    repeat ($urandom_range(1, 100)) @(negedge clk);
    rst = 1'b1; mode = 1'b0;
    @(negedge clk);
    total++;
    if ({pdm_clk, pdm_data, in_ready, underrun} !== 4'b0010)
      $display("FAIL midreset_abort clk,data,rdy,und got %b want 0010", {pdm_clk, pdm_data, in_ready, underrun});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    half = 64;
    model_reset();
    for (int p = 1; p <= 6; p++) begin
      run_period(1'b0, 16'h0, 16'h0, ol, orr, orp, orq, ou, nw);
      model_period(1'b0, 16'h0, 16'h0, el, er, erp, erq, eu);
      if (p == 1) begin
        total++; if (nw !== 64) $display("FAIL midreset_first_rise got %0d want 64", nw); else pass_cnt++;
      end
      total++;
      if ({ol, orr, ou} !== {1'((p - 1) % 2), 1'(p % 2), 1'b0})
        $display("FAIL midreset_restart p%0d l,r,und got %b want %b", p, {ol, orr, ou},
                 {1'((p - 1) % 2), 1'(p % 2), 1'b0});
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    @(negedge clk);
    test_reset();
    test_rate();
    test_pattern();
    test_handshake();
    test_underrun();
    test_wrap_accept();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
